dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single data memory port (mem_read/mem_write, address, write data, read data) between two requesters: the CPU memory stage (port 0, "cpu") and a program/data loader or debug port (port 1, "ldr").
- Inserts a configurable number of wait states per access.
- Returns a registered acknowledge and read data to each requester.
- Drives a stall to the pipeline while a CPU access is outstanding.

Parameters:
- WAIT_CYCLES, 1, number of cycles mem_read/mem_write are held per access (legal range 1..15).
- ADDR_W, `WORD, width of address fields.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request; held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  CPU byte address (ALU result)
- cpu_wdata  input  `WORD  CPU store data
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  `WORD  load data, valid when cpu_ack && !cpu_we of the access
- cpu_stall  output  1  cpu_req && !cpu_ack (combinational)
- ldr_req  input  1  loader access request
- ldr_we  input  1  loader write enable
- ldr_addr  input  ADDR_W  loader address
- ldr_wdata  input  `WORD  loader write data
- ldr_ack  output  1  one-cycle completion pulse
- ldr_rdata  output  `WORD  loader read data
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  `WORD  memory write data
- mem_rdata  input  `WORD  memory read data

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE; all outputs 0 (except cpu_stall, which follows cpu_req); wait counter 0; latched request fields 0; round-robin pointer = "ldr last served".
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, pick a winner.
  - Latch the winner's we/addr/wdata and its ID, load the counter with WAIT_CYCLES-1, then go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata come from the latched fields.
  - mem_read = !we_latched and mem_write = we_latched, held high every ACCESS cycle.
  - Counter decrements each cycle. When the counter is 0, capture mem_rdata into the winner's rdata register at that edge, then go to DONE.
- DONE:
  - mem strobes are 0.
  - The winner's ack is 1 for exactly one cycle; rdata holds the captured value until that port's next read.
  - Next state is IDLE.
- Latency: request seen in IDLE → ack WAIT_CYCLES+1 cycles later. Throughput: one access per WAIT_CYCLES+2 cycles.
- Requester handshake rules:
  - Request fields must be stable from req rise until ack.
  - A req dropped mid-access does not abort; the access completes and ack still pulses.
  - A req still high in the cycle after ack is a new request.
- Default arbitration: fixed priority, cpu wins over ldr when both request in IDLE.
- rdata of a write access is unchanged (no capture).
- Reset asserted mid-ACCESS: strobes drop immediately, no ack is issued, state returns to IDLE.
- Out-of-range WAIT_CYCLES is not supported. The counter is 4 bits; WAIT_CYCLES=1 gives a single ACCESS cycle.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests in IDLE, grant the port not served last; the pointer updates on each grant. Single requests are always granted.
- Undefined: fixed priority, cpu first; no pointer register.

Decomposition:
- definitions.vh (shared package) gains:
  - state encodings `ARB_IDLE, `ARB_ACCESS, `ARB_DONE (2 bits);
  - requester IDs `ARB_CPU=0, `ARB_LDR=1;
  - `ARB_CNT_W=4.
- It continues to supply `WORD and `CYCLE.
- One natural sub-module: arb_wait_counter (load, decrement, zero flag, async active-low reset on clk/rst_n).
- Arbitration pick stays inline.

Test Plan:
- CPU read, WAIT_CYCLES=1: cpu_req=1, we=0, addr=1; mem_rdata=1234 → mem_read high 1 cycle with mem_addr=1; cpu_ack pulse 2 cycles after req; cpu_rdata=1234; cpu_stall high until ack.
- CPU write then read-back: write addr=2 data=1234, then read addr=2 → mem_write high with mem_wdata=1234; the subsequent read returns 1234 via the memory model; mem_read never high during the write.
- Simultaneous cpu_req and ldr_req (addr 8 and 16):
  - without DMEM_ARB_RR_EN → cpu served first, ldr_ack 3 cycles after cpu_ack;
  - with the macro, both held high repeatedly → grants alternate cpu, ldr, cpu.
- WAIT_CYCLES=4, ldr read addr=5 → mem_read held exactly 4 cycles; ldr_ack 5 cycles after req; cpu_stall stays 0.
- rst_n pulled low in the 2nd ACCESS cycle (WAIT_CYCLES=3) → mem_read drops asynchronously; no ack; after release with no req, FSM stays IDLE and all outputs stay 0.
- Requester drops cpu_req mid-ACCESS → access completes, cpu_ack still pulses once; no second access is started.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and types for the data-memory arbiter.
// Requester IDs, FSM state codes and the wait-counter width.
package dmem_arbiter_pkg;

  localparam int WORD_W    = 32;
  localparam int CYCLE_W   = 32;
  localparam int ARB_CNT_W = 4;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_DONE   = 2'd2;

  localparam logic ARB_CPU = 1'b0;
  localparam logic ARB_LDR = 1'b1;

  typedef struct packed {
    logic id;
    logic we;
  } arb_ctl_t;

  // Winner ID; with both requesting, the port not served last wins
  function automatic logic arb_pick_rr(
    input logic cpu,
    input logic ldr,
    input logic last
  );
    return (cpu && ldr) ? ~last : ~cpu;
  endfunction

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Wait-state down-counter for the data-memory arbiter.
// Loads a start value, decrements to zero, flags zero.
module arb_wait_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int W = ARB_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (cpu / loader) with wait states.
// Build option DMEM_ARB_RR_EN selects round-robin over fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [WORD_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [WORD_W-1:0] ldr_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [ARB_CNT_W-1:0] CNT_INIT =
    ARB_CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  arb_ctl_t          ctl;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] cpu_rdata_q;
  logic [WORD_W-1:0] ldr_rdata_q;

  logic st_idle;
  logic st_access;
  logic st_done;
  logic any_req;
  logic grant;
  logic pick;
  logic cnt_zero;

  assign st_idle   = (state == ARB_IDLE);
  assign st_access = (state == ARB_ACCESS);
  assign st_done   = (state == ARB_DONE);
  assign any_req   = cpu_req | ldr_req;
  assign grant     = st_idle & any_req;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  assign pick = arb_pick_rr(cpu_req, ldr_req, last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ARB_LDR;
    end else if (grant) begin
      last_q <= pick;
    end
  end
`else
  assign pick = cpu_req ? ARB_CPU : ARB_LDR;
`endif

  arb_wait_counter #(
    .W (ARB_CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant),
    .load_val (CNT_INIT),
    .dec      (st_access),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      ctl         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (any_req) begin
            state   <= ARB_ACCESS;
            ctl.id  <= pick;
            ctl.we  <= pick ? ldr_we : cpu_we;
            addr_q  <= pick ? ldr_addr : cpu_addr;
            wdata_q <= pick ? ldr_wdata : cpu_wdata;
          end
        end
        st_access: begin
          if (cnt_zero) begin
            state <= ARB_DONE;
            // Writes leave the requester's read data untouched
            if (!ctl.we) begin
              if (ctl.id == ARB_LDR) begin
                ldr_rdata_q <= mem_rdata;
              end else begin
                cpu_rdata_q <= mem_rdata;
              end
            end
          end
        end
        st_done: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_read  = st_access & ~ctl.we;
  assign mem_write = st_access & ctl.we;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cpu_ack   = st_done & (ctl.id == ARB_CPU);
  assign ldr_ack   = st_done & (ctl.id == ARB_LDR);
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instances with WAIT_CYCLES 1, 3, 4.
// Define DMEM_ARB_RR_EN for both RTL and bench to check round-robin.
module tb_dmem_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [NI-1:0]       rst_n, cpu_req, cpu_we, ldr_req, ldr_we;
  logic [NI-1:0]       cpu_ack, cpu_stall, ldr_ack, mem_read, mem_write;
  logic [NI-1:0][31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [NI-1:0][31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic [NI-1:0][31:0] mem_addr, mem_wdata, mem_rdata;
  logic [NI-1:0]       use_ovr;
  logic [NI-1:0][31:0] ovr;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] mem [256];

    dmem_arbiter #(
      .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .ADDR_W      (32)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_ack   (cpu_ack[g]),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_stall (cpu_stall[g]),
      .ldr_req   (ldr_req[g]),
      .ldr_we    (ldr_we[g]),
      .ldr_addr  (ldr_addr[g]),
      .ldr_wdata (ldr_wdata[g]),
      .ldr_ack   (ldr_ack[g]),
      .ldr_rdata (ldr_rdata[g]),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    assign mem_rdata[g] = use_ovr[g] ? ovr[g] : mem[mem_addr[g][7:0]];

    always @(posedge clk) begin
      if (mem_write[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
    end
  end

  // One access on instance g; called just after a falling edge
  task automatic xfer(
    input  int          g,
    input  bit          ldr,
    input  bit          we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          lat,
    output logic [31:0] rd,
    output int          rcyc,
    output int          wcyc,
    output logic [31:0] maddr,
    output logic [31:0] mwd,
    output bit          stall_seen
  );
    if (ldr) begin
      ldr_req[g] = 1'b1; ldr_we[g] = we;
      ldr_addr[g] = a; ldr_wdata[g] = d;
    end else begin
      cpu_req[g] = 1'b1; cpu_we[g] = we;
      cpu_addr[g] = a; cpu_wdata[g] = d;
    end
    lat = -1; rd = '0; rcyc = 0; wcyc = 0;
    maddr = '1; mwd = '1; stall_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      rcyc += int'(mem_read[g]);
      wcyc += int'(mem_write[g]);
      if (mem_read[g] || mem_write[g]) begin
        maddr = mem_addr[g]; mwd = mem_wdata[g];
      end
      if (cpu_stall[g]) stall_seen = 1'b1;
      if (ldr ? ldr_ack[g] : cpu_ack[g]) begin
        lat = i;
        rd = ldr ? ldr_rdata[g] : cpu_rdata[g];
        break;
      end
    end
    cpu_req[g] = 1'b0;
    ldr_req[g] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = '0; cpu_req = '0; cpu_we = '0; ldr_req = '0; ldr_we = '0;
    cpu_addr = '0; cpu_wdata = '0; ldr_addr = '0; ldr_wdata = '0;
    use_ovr = '0; ovr = '0;
    repeat (2) @(negedge clk);
    rst_n = '1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      n_cmp++;
      if ({cpu_ack[g], ldr_ack[g], mem_read[g], mem_write[g], cpu_stall[g]} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_ctl[%0d]: got %b want 00000", g,
          {cpu_ack[g], ldr_ack[g], mem_read[g], mem_write[g], cpu_stall[g]});
      end
      n_cmp++;
      if ({mem_addr[g], mem_wdata[g], cpu_rdata[g], ldr_rdata[g]} !== 128'h0) begin
        n_bad++;
        $display("FAIL reset_data[%0d]: addr %0h wdata %0h crd %0h lrd %0h want 0",
          g, mem_addr[g], mem_wdata[g], cpu_rdata[g], ldr_rdata[g]);
      end
    end
  endtask

  task automatic test_cpu_read();
    int lat, rc, wc; logic [31:0] rd, ma, mw; bit st;
    use_ovr[0] = 1'b1; ovr[0] = 32'd1234;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0;
    #1;
    n_cmp++;
    if (cpu_stall[0] !== 1'b1) begin
      n_bad++; $display("FAIL rd_stall_on: got %b want 1", cpu_stall[0]);
    end
    xfer(0, 1'b0, 1'b0, 32'd1, 32'd0, lat, rd, rc, wc, ma, mw, st);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL rd_lat: got %0d want 2", lat); end
    n_cmp++;
    if (rd !== 32'd1234) begin n_bad++; $display("FAIL rd_data: got %0d want 1234", rd); end
    n_cmp++;
    if (rc !== 1 || wc !== 0) begin
      n_bad++; $display("FAIL rd_strobes: read %0d write %0d want 1 0", rc, wc);
    end
    n_cmp++;
    if (ma !== 32'd1) begin n_bad++; $display("FAIL rd_addr: got %0h want 1", ma); end
    n_cmp++;
    if (st !== 1'b1) begin n_bad++; $display("FAIL rd_stall_hi: got %b want 1", st); end
    #1;
    n_cmp++;
    if (cpu_stall[0] !== 1'b0) begin
      n_bad++; $display("FAIL rd_stall_ack: got %b want 0", cpu_stall[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_write_readback();
    int lat, rc, wc; logic [31:0] rd, ma, mw; bit st;
    use_ovr[0] = 1'b0;
    xfer(0, 1'b0, 1'b1, 32'd2, 32'd1234, lat, rd, rc, wc, ma, mw, st);
    n_cmp++;
    if (lat !== 2 || wc !== 1 || rc !== 0) begin
      n_bad++; $display("FAIL wr_seq: lat %0d write %0d read %0d want 2 1 0", lat, wc, rc);
    end
    n_cmp++;
    if (ma !== 32'd2 || mw !== 32'd1234) begin
      n_bad++; $display("FAIL wr_bus: addr %0h data %0d want 2 1234", ma, mw);
    end
    @(negedge clk);
    xfer(0, 1'b0, 1'b1, 32'd3, 32'h55, lat, rd, rc, wc, ma, mw, st);
    n_cmp++;
    if (rd !== 32'd1234) begin
      n_bad++; $display("FAIL wr_keeps_rdata: got %0d want 1234", rd);
    end
    @(negedge clk);
    xfer(0, 1'b0, 1'b0, 32'd2, 32'd0, lat, rd, rc, wc, ma, mw, st);
    n_cmp++;
    if (rd !== 32'd1234 || rc !== 1 || wc !== 0) begin
      n_bad++; $display("FAIL readback: data %0d read %0d write %0d want 1234 1 0", rd, rc, wc);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int t [3];
    bit who [3];
    int k;
    logic [31:0] first_a;
    use_ovr[0] = 1'b1; ovr[0] = 32'hABCD;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'd8;
    ldr_req[0] = 1'b1; ldr_we[0] = 1'b0; ldr_addr[0] = 32'd16;
    k = 0; first_a = '1;
    for (int i = 0; i < 3; i++) begin t[i] = -1; who[i] = 1'b0; end
    for (int i = 1; i <= 20 && k < 3; i++) begin
      @(negedge clk);
      if (mem_read[0] && first_a === '1) first_a = mem_addr[0];
      if (cpu_ack[0] || ldr_ack[0]) begin
        t[k] = i; who[k] = ldr_ack[0]; k++;
`ifndef DMEM_ARB_RR_EN
        if (cpu_ack[0]) cpu_req[0] = 1'b0;
        if (ldr_ack[0]) ldr_req[0] = 1'b0;
        if (k == 2) break;
`endif
      end
    end
    cpu_req[0] = 1'b0; ldr_req[0] = 1'b0;
    n_cmp++;
    if (first_a !== 32'd8) begin n_bad++; $display("FAIL sim_first_addr: got %0h want 8", first_a); end
    n_cmp++;
    if (t[0] !== 2 || who[0] !== 1'b0) begin
      n_bad++; $display("FAIL sim_grant0: t %0d ldr %b want 2 0", t[0], who[0]);
    end
    n_cmp++;
    if (t[1] !== 5 || who[1] !== 1'b1) begin
      n_bad++; $display("FAIL sim_grant1: t %0d ldr %b want 5 1", t[1], who[1]);
    end
`ifdef DMEM_ARB_RR_EN
    n_cmp++;
    if (t[2] !== 8 || who[2] !== 1'b0) begin
      n_bad++; $display("FAIL sim_grant2: t %0d ldr %b want 8 0", t[2], who[2]);
    end
`endif
    repeat (8) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = -1; t2 = -1;
    use_ovr[0] = 1'b1; ovr[0] = 32'h77;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'd1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (cpu_ack[0]) begin
        if (t1 < 0) t1 = i;
        else begin t2 = i; cpu_req[0] = 1'b0; break; end
      end
    end
    cpu_req[0] = 1'b0;
    n_cmp++;
    if (t1 !== 2 || t2 !== 5) begin
      n_bad++; $display("FAIL b2b_acks: got %0d %0d want 2 5", t1, t2);
    end
    @(negedge clk);
  endtask

  task automatic test_wait4_ldr();
    int lat, rc, wc; logic [31:0] rd, ma, mw; bit st;
    use_ovr[2] = 1'b1; ovr[2] = 32'hCAFE0005;
    @(negedge clk);
    xfer(2, 1'b1, 1'b0, 32'd5, 32'd0, lat, rd, rc, wc, ma, mw, st);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL w4_lat: got %0d want 5", lat); end
    n_cmp++;
    if (rc !== 4 || wc !== 0) begin
      n_bad++; $display("FAIL w4_strobes: read %0d write %0d want 4 0", rc, wc);
    end
    n_cmp++;
    if (rd !== 32'hCAFE0005 || ma !== 32'd5) begin
      n_bad++; $display("FAIL w4_data: data %0h addr %0h want cafe0005 5", rd, ma);
    end
    n_cmp++;
    if (st !== 1'b0) begin n_bad++; $display("FAIL w4_stall: got %b want 0", st); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    use_ovr[1] = 1'b1; ovr[1] = 32'h1111;
    @(negedge clk);
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'd7;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_read[1] !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre_read: got %b want 1", mem_read[1]);
    end
    rst_n[1] = 1'b0;
    cpu_req[1] = 1'b0;
    #1;
    n_cmp++;
    if (mem_read[1] !== 1'b0) begin
      n_bad++; $display("FAIL rst_async_drop: got %b want 0", mem_read[1]);
    end
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cpu_ack[1], ldr_ack[1], mem_read[1], mem_write[1], cpu_stall[1]} !== 5'b0
          || mem_addr[1] !== 32'd0 || cpu_rdata[1] !== 32'd0) begin
        n_bad++;
        $display("FAIL rst_quiet[%0d]: ctl %b addr %0h rdata %0h want 0 0 0", i,
          {cpu_ack[1], ldr_ack[1], mem_read[1], mem_write[1], cpu_stall[1]},
          mem_addr[1], cpu_rdata[1]);
      end
    end
  endtask

  task automatic test_drop_mid();
    int acks, rc;
    use_ovr[2] = 1'b1; ovr[2] = 32'h99;
    @(negedge clk);
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 32'd9;
    @(negedge clk);
    rc = int'(mem_read[2]);
    acks = 0;
    cpu_req[2] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rc += int'(mem_read[2]);
      acks += int'(cpu_ack[2]);
    end
    n_cmp++;
    if (acks !== 1) begin n_bad++; $display("FAIL drop_acks: got %0d want 1", acks); end
    n_cmp++;
    if (rc !== 4) begin n_bad++; $display("FAIL drop_reads: got %0d want 4", rc); end
    n_cmp++;
    if (cpu_rdata[2] !== 32'h99) begin
      n_bad++; $display("FAIL drop_rdata: got %0h want 99", cpu_rdata[2]);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_readback();
    test_simultaneous();
    test_back_to_back();
    test_wait4_ldr();
    test_reset_mid();
    test_drop_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
